// File: rtl/pos_dec_pkg.sv
// Shared types and constants for the pos_dec measurement-window sequencer.
package pos_dec_pkg;

  localparam int unsigned POS_TH_W  = 5;
  localparam int unsigned WIN_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [WIN_W_DEF-1:0] NO_ERR_POS = '1;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StMeasure,
    StReport
  } state_e;

endpackage

// File: rtl/pos_err_acc.sv
// Saturating error counter with first-error timestamp capture.
module pos_err_acc #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_err,
  input  logic [WIN_W-1:0] i_idx,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic [WIN_W-1:0] o_first
);

  logic [CNT_W-1:0] r_cnt;
  logic [WIN_W-1:0] r_first;
  logic             w_hit;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_hit     = i_en & i_err;
    w_cnt_nxt = r_cnt;
    if (w_hit && (r_cnt != '1)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // A zero count means no pulse seen yet, since the counter saturates instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_first <= '1;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_first <= '1;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_hit && (r_cnt == '0)) begin
        r_first <= i_idx;
      end
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_first   = r_first;

endmodule

// File: rtl/pos_dec_ctrl.sv
// Measurement-window sequencer: settle, enable pos_dec for a window, report pass/fail.
module pos_dec_ctrl
  import pos_dec_pkg::*;
#(
  parameter int unsigned WIN_W      = WIN_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter bit          EARLY_STOP = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [POS_TH_W-1:0] i_cfg_pos_th,
  input  logic [7:0]          i_cfg_settle,
  input  logic [WIN_W-1:0]    i_cfg_win,
  input  logic [CNT_W-1:0]    i_cfg_err_lim,
  input  logic                i_dec_err_vld,
  output logic                o_dec_en,
  output logic [POS_TH_W-1:0] o_dec_pos_th,
  output logic                o_busy,
  output logic                o_res_vld,
  input  logic                i_res_rdy,
  output logic [CNT_W-1:0]    o_res_err_cnt,
  output logic [WIN_W-1:0]    o_res_first,
  output logic                o_res_fail
);

  state_e              r_state, w_state_nxt;
  logic [POS_TH_W-1:0] r_pos_th;
  logic [7:0]          r_settle_cnt;
  logic [WIN_W-1:0]    r_win_last;
  logic [WIN_W-1:0]    r_win_idx;
  logic [CNT_W-1:0]    r_err_lim;
  logic                r_fail;
  logic                w_start;
  logic                w_stop;
  logic                w_measure;
  logic [CNT_W-1:0]    w_cnt_nxt;

  assign w_measure = (r_state == StMeasure);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = (r_win_idx == r_win_last) || (EARLY_STOP && (w_cnt_nxt >= r_err_lim));
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_start     = 1'b1;
          w_state_nxt = (i_cfg_settle != 8'd0) ? StSettle : StMeasure;
        end
      end
      StSettle:  if (r_settle_cnt <= 8'd1) w_state_nxt = StMeasure;
      StMeasure: if (w_stop) w_state_nxt = StReport;
      StReport:  if (i_res_rdy) w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
    if (i_abort) begin
      w_state_nxt = StIdle;
      w_start     = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  // Window terminal index is stored instead of the raw length so a length of 0 acts as 1.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pos_th     <= '0;
      r_settle_cnt <= '0;
      r_win_last   <= '0;
      r_win_idx    <= '0;
      r_err_lim    <= '0;
      r_fail       <= 1'b0;
    end else if (w_start) begin
      r_pos_th     <= i_cfg_pos_th;
      r_settle_cnt <= i_cfg_settle;
      r_win_last   <= (i_cfg_win == '0) ? '0 : i_cfg_win - WIN_W'(1);
      r_win_idx    <= '0;
      r_err_lim    <= i_cfg_err_lim;
      r_fail       <= 1'b0;
    end else begin
      if ((r_state == StSettle) && (r_settle_cnt != 8'd0)) begin
        r_settle_cnt <= r_settle_cnt - 8'd1;
      end
      if (w_measure) begin
        r_fail <= (w_cnt_nxt >= r_err_lim);
        if (!w_stop) r_win_idx <= r_win_idx + WIN_W'(1);
      end
    end
  end

  pos_err_acc #(
    .CNT_W (CNT_W),
    .WIN_W (WIN_W)
  ) u_err_acc (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_start),
    .i_en      (w_measure),
    .i_err     (i_dec_err_vld),
    .i_idx     (r_win_idx),
    .o_cnt     (o_res_err_cnt),
    .o_cnt_nxt (w_cnt_nxt),
    .o_first   (o_res_first)
  );

  assign o_dec_en     = w_measure;
  assign o_dec_pos_th = r_pos_th;
  assign o_busy       = (r_state != StIdle);
  assign o_res_vld    = (r_state == StReport);
  assign o_res_fail   = r_fail;

endmodule

// File: doc/pos_dec_ctrl.md
Name: pos_dec_ctrl

Overview:
- Measurement-window sequencer for the ADC position-error detector (pos_dec).
- On a start command it latches the configuration, waits a settle time, then enables the detector for a programmed window.
- During the window it counts and timestamps detector error pulses, then presents a pass/fail result over a valid/ready handshake.
- Sits between the register/config interface and the pos_dec instance.

Parameters:
- WIN_W, 16, width of the window length, window cycle index and first-error timestamp.
- CNT_W, 8, width of the error counter and error limit.
- EARLY_STOP, 0, when 1, MEASURE ends as soon as the error count reaches the limit.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle command; honoured only in IDLE.
- abort  in  1  single-cycle command; returns to IDLE from any state, no result.
- cfg_pos_th  in  5  detector threshold; latched at start.
- cfg_settle  in  8  settle cycles before measuring; latched at start.
- cfg_win  in  WIN_W  measurement window length in cycles; latched at start; 0 is treated as 1.
- cfg_err_lim  in  CNT_W  fail limit; latched at start; 0 means always fail.
- dec_err_vld  in  1  error pulse from pos_dec.
- dec_en  out  1  detector enable; high only in MEASURE.
- dec_pos_th  out  5  latched threshold driven to pos_dec.
- busy  out  1  high in any state except IDLE.
- res_vld  out  1  result valid; high in REPORT.
- res_rdy  in  1  result accept.
- res_err_cnt  out  CNT_W  saturating error count for the window.
- res_first  out  WIN_W  window cycle index of the first error; all-ones if none.
- res_fail  out  1  1 when res_err_cnt >= limit.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE.
  - All outputs 0, except res_first = all-ones.
  - Latched config cleared to 0.
- States: IDLE, SETTLE, MEASURE, REPORT.
- IDLE:
  - On start (without abort), at that edge: latch all cfg_* inputs, clear the error count, set res_first to all-ones, load the settle counter.
  - Next state is SETTLE if cfg_settle != 0, else MEASURE.
- SETTLE:
  - Counts down the latched settle value; stays exactly cfg_settle cycles, then goes to MEASURE.
  - dec_en = 0; dec_err_vld is ignored.
- MEASURE:
  - dec_en = 1; the window index runs 0 .. win_eff-1, where win_eff = max(cfg_win, 1).
  - A cycle with dec_err_vld = 1 increments the count, saturating at 2^CNT_W-1.
  - On the first such pulse, res_first is set to the current index.
  - After the cycle with index win_eff-1, go to REPORT. The error from that last cycle is counted.
  - If EARLY_STOP = 1 and the post-increment count >= limit, go to REPORT after the current cycle; res_first still holds.
- REPORT:
  - res_vld = 1; res_err_cnt, res_first and res_fail are stable until handshake.
  - res_vld falls only on a cycle where res_vld & res_rdy; the next state is IDLE.
  - res_rdy in other states is ignored.
- dec_pos_th:
  - Follows the latched threshold from the cycle after start until the next start.
  - It is stable throughout SETTLE and MEASURE, so the detector sees a constant threshold.
- Result fields keep their values in IDLE after the handshake until the next start clears them.
- abort:
  - Highest priority. At the edge where abort = 1, go to IDLE.
  - dec_en and res_vld are 0 on the next cycle; the count is retained but no result is presented.
  - abort together with start in IDLE: abort wins and start is dropped.
- start while busy: ignored, no relatch.
- dec_err_vld in IDLE, SETTLE or REPORT: ignored.
- Arithmetic: all counters are unsigned. The fail compare is done at CNT_W bits. The window index never wraps, because its terminal value is win_eff-1 <= 2^WIN_W-1.
- Latency:
  - start to first MEASURE cycle = cfg_settle+1 cycles.
  - Last MEASURE cycle to res_vld = 1 cycle.

Decomposition:
- Shared package pos_dec_pkg:
  - state enum (IDLE/SETTLE/MEASURE/REPORT).
  - POS_TH_W = 5, default WIN_W and CNT_W.
  - NO_ERR_POS constant (all-ones).
- One sub-module, pos_err_acc: saturating error counter plus first-error timestamp capture, with clear/enable inputs.
- The FSM and the settle/window counters stay in the top module.

Test Plan:
- Settle 3, win 10, lim 2, errors at window idx 4 and 7 -> dec_en high for exactly 10 cycles, starting 4 cycles after start; result cnt=2, first=4, fail=1.
- Settle 0, win 0, error on the only MEASURE cycle -> MEASURE lasts 1 cycle, the cycle after start; cnt=1, first=0; lim 5 gives fail=0.
- Window with no errors, res_rdy held low 20 cycles -> res_vld and fields stable for all 20 cycles; cnt=0, first=16'hFFFF, fail=0; IDLE the cycle after rdy.
- dec_err_vld held high for 300 MEASURE cycles (win 300) -> cnt saturates at 255; first=0.
- EARLY_STOP=1, lim 3, errors at idx 1, 2, 5 with win 50 -> REPORT entered after idx 5; cnt=3, fail=1.
- Checks on command priority and mid-run reset:
  - abort in MEASURE at idx 6 -> next cycle IDLE, dec_en=0, res_vld never asserted.
  - start during SETTLE with different cfg -> ignored; dec_pos_th unchanged.
  - rst_n low mid-MEASURE -> all outputs return to reset values on the next edge.
